// File: rtl/ex_stage.sv
// ex_stage: execute stage with operand forwarding, ALU, branch target and EX/MEM register
module ex_stage #(
  parameter int WIDTH = 32,
  parameter int REGW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pcin,
  input  logic [WIDTH-1:0] regd0in,
  input  logic [WIDTH-1:0] regd1in,
  input  logic [WIDTH-1:0] instexin,
  input  logic [REGW-1:0]  inst0in,
  input  logic [REGW-1:0]  inst1in,
  input  logic             regdstin,
  input  logic [1:0]       aluopin,
  input  logic             alusrcin,
  input  logic             branchin,
  input  logic             memreadin,
  input  logic             memwritein,
  input  logic             regwritein,
  input  logic             memtoregin,
  input  logic [1:0]       fwda,
  input  logic [1:0]       fwdb,
  input  logic [WIDTH-1:0] wbdata,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] aluresult,
  output logic [WIDTH-1:0] storedata,
  output logic [WIDTH-1:0] branchtarget,
  output logic             zero,
  output logic             pcsrc,
  output logic [REGW-1:0]  writereg,
  output logic             memread,
  output logic             memwrite,
  output logic             regwrite,
  output logic             memtoreg
);
  typedef struct packed {
    logic [WIDTH-1:0] aluresult;
    logic [WIDTH-1:0] storedata;
    logic [WIDTH-1:0] branchtarget;
    logic             zero;
    logic             pcsrc;
    logic [REGW-1:0]  writereg;
    logic             memread;
    logic             memwrite;
    logic             regwrite;
    logic             memtoreg;
  } ex_mem_t;
  ex_mem_t ex_mem_d, ex_mem_q, nxt;
  logic [WIDTH-1:0] op_a, fwd_b, op_b, r_res;
  always_comb begin
    op_a = fwda == 2'b01 ? wbdata : fwda == 2'b10 ? ex_mem_q.aluresult : regd0in;
    fwd_b = fwdb == 2'b01 ? wbdata : fwdb == 2'b10 ? ex_mem_q.aluresult : regd1in;
    op_b = alusrcin ? instexin : fwd_b;
    case (instexin[5:0])
      6'b100000: r_res = op_a + op_b;
      6'b100010: r_res = op_a - op_b;
      6'b100100: r_res = op_a & op_b;
      6'b100101: r_res = op_a | op_b;
      6'b101010: r_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      6'b100111: r_res = ~(op_a | op_b);
      default:   r_res = '0;
    endcase
    nxt.aluresult = aluopin == 2'b00 ? op_a + op_b :
                    aluopin == 2'b01 ? op_a - op_b :
                    aluopin == 2'b11 ? op_a | op_b : r_res;
    nxt.storedata = fwd_b;
    nxt.branchtarget = pcin + (instexin << 2);
    nxt.zero = nxt.aluresult == '0;
    nxt.pcsrc = branchin & nxt.zero;
    nxt.writereg = regdstin ? inst1in : inst0in;
    nxt.memread = memreadin;
    nxt.memwrite = memwritein;
    nxt.regwrite = regwritein;
    nxt.memtoreg = memtoregin;
    ex_mem_d = flush ? '0 : stall ? ex_mem_q : nxt;
  end
  always_ff @(posedge clk) ex_mem_q <= rst ? '0 : ex_mem_d;
  assign aluresult = ex_mem_q.aluresult;
  assign storedata = ex_mem_q.storedata;
  assign branchtarget = ex_mem_q.branchtarget;
  assign zero = ex_mem_q.zero;
  assign pcsrc = ex_mem_q.pcsrc;
  assign writereg = ex_mem_q.writereg;
  assign memread = ex_mem_q.memread;
  assign memwrite = ex_mem_q.memwrite;
  assign regwrite = ex_mem_q.regwrite;
  assign memtoreg = ex_mem_q.memtoreg;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and random checks of ex_stage against a behavioural model
module tb_ex_stage;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, regdstin, alusrcin, branchin, memreadin, memwritein, regwritein, memtoregin, stall, flush;
  logic [31:0] pcin, regd0in, regd1in, instexin, wbdata;
  logic [4:0] inst0in, inst1in;
  logic [1:0] aluopin, fwda, fwdb;
  logic [31:0] aluresult, storedata, branchtarget;
  logic zero, pcsrc, memread, memwrite, regwrite, memtoreg;
  logic [4:0] writereg;
  int checks = 0, errors = 0;
  logic [31:0] m_alu, m_sd, m_bt;
  logic [4:0] m_wr;
  logic m_z, m_pc, m_mr, m_mw, m_rw, m_mt;

  ex_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk(clk), .rst(rst), .pcin(pcin), .regd0in(regd0in), .regd1in(regd1in),
    .instexin(instexin), .inst0in(inst0in), .inst1in(inst1in), .regdstin(regdstin),
    .aluopin(aluopin), .alusrcin(alusrcin), .branchin(branchin), .memreadin(memreadin),
    .memwritein(memwritein), .regwritein(regwritein), .memtoregin(memtoregin),
    .fwda(fwda), .fwdb(fwdb), .wbdata(wbdata), .stall(stall), .flush(flush),
    .aluresult(aluresult), .storedata(storedata), .branchtarget(branchtarget),
    .zero(zero), .pcsrc(pcsrc), .writereg(writereg), .memread(memread),
    .memwrite(memwrite), .regwrite(regwrite), .memtoreg(memtoreg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op, input logic [5:0] f);
    if (op == 2'd0) return a + b;
    if (op == 2'd1) return a - b;
    if (op == 2'd3) return a | b;
    case (f)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h2a: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      6'h27: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  task automatic step();
    logic [31:0] a, fb, r;
    a = fwda == 2'd1 ? wbdata : fwda == 2'd2 ? m_alu : regd0in;
    fb = fwdb == 2'd1 ? wbdata : fwdb == 2'd2 ? m_alu : regd1in;
    r = alu_ref(a, alusrcin ? instexin : fb, aluopin, instexin[5:0]);
    if (rst || flush) begin
      {m_alu, m_sd, m_bt, m_wr} = '0;
      {m_z, m_pc, m_mr, m_mw, m_rw, m_mt} = '0;
    end else if (!stall) begin
      m_alu = r;
      m_sd = fb;
      m_bt = pcin + instexin * 4;
      m_z = (r == 0);
      m_pc = branchin && (r == 0);
      m_wr = regdstin ? inst1in : inst0in;
      {m_mr, m_mw, m_rw, m_mt} = {memreadin, memwritein, regwritein, memtoregin};
    end
    @(posedge clk);
    #1;
    check("aluresult", aluresult, m_alu);
    check("storedata", storedata, m_sd);
    check("branchtarget", branchtarget, m_bt);
    check("zero", {31'd0, zero}, {31'd0, m_z});
    check("pcsrc", {31'd0, pcsrc}, {31'd0, m_pc});
    check("writereg", {27'd0, writereg}, {27'd0, m_wr});
    check("ctrl", {28'd0, memread, memwrite, regwrite, memtoreg}, {28'd0, m_mr, m_mw, m_rw, m_mt});
  endtask

  task automatic clear_in();
    {rst, regdstin, alusrcin, branchin, memreadin, memwritein, regwritein, memtoregin, stall, flush} = '0;
    {pcin, regd0in, regd1in, instexin, wbdata} = '0;
    {inst0in, inst1in, aluopin, fwda, fwdb} = '0;
  endtask

  task automatic rand_in();
    logic [5:0] functs [7];
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h00};
    clear_in();
    pcin = $urandom; regd0in = $urandom; regd1in = $urandom; instexin = $urandom; wbdata = $urandom;
    inst0in = 5'($urandom); inst1in = 5'($urandom);
    aluopin = 2'($urandom); fwda = 2'($urandom); fwdb = 2'($urandom);
    {regdstin, alusrcin, branchin, memreadin, memwritein, regwritein, memtoregin} = 7'($urandom);
    if ($urandom_range(0, 4) != 0) instexin[5:0] = functs[$urandom_range(0, 6)];
    if ($urandom_range(0, 5) == 0) regd1in = regd0in;
  endtask

  initial begin
    {m_alu, m_sd, m_bt, m_wr} = '0;
    {m_z, m_pc, m_mr, m_mw, m_rw, m_mt} = '0;
    rand_in(); rst = 1; step();
    rand_in(); rst = 1; step();
    rand_in(); rst = 1; flush = 1; step();
    check("reset_alu", aluresult, 0);
    clear_in(); regd0in = 5; regd1in = 7; aluopin = 2; instexin = 32'h20; regdstin = 1; inst1in = 3; regwritein = 1;
    step();
    check("radd_alu", aluresult, 12); check("radd_wr", {27'd0, writereg}, 3);
    check("radd_rw", {31'd0, regwrite}, 1); check("radd_zero", {31'd0, zero}, 0);
    clear_in(); pcin = 32'h40; instexin = 32'hFFFFFFFE; regd0in = 9; regd1in = 9; aluopin = 1; branchin = 1;
    step();
    check("br_pcsrc", {31'd0, pcsrc}, 1); check("br_target", branchtarget, 32'h38);
    clear_in(); regd0in = 32'h10; step();
    clear_in(); fwda = 2; fwdb = 1; wbdata = 3; aluopin = 2; instexin = 32'h22; regd0in = 32'h99; regd1in = 32'h77;
    step();
    check("fwd_sub", aluresult, 32'h0D);
    clear_in(); regd0in = 32'hFFFFFFFF; regd1in = 1; aluopin = 2; instexin = 32'h2a; step();
    check("slt_neg", aluresult, 1);
    clear_in(); alusrcin = 1; regd0in = 32'h100; regd1in = 32'hAB; instexin = 8; memwritein = 1; step();
    check("sw_sd", storedata, 32'hAB); check("sw_alu", aluresult, 32'h108);
    for (int i = 0; i < 3; i++) begin
      rand_in(); stall = 1; step();
      check("stall_sd", storedata, 32'hAB);
    end
    rand_in(); stall = 1; flush = 1; step();
    check("flush_mw", {31'd0, memwrite}, 0);
    clear_in(); regd0in = 32'hFFFFFFFF; instexin = 1; alusrcin = 1; step();
    check("wrap_alu", aluresult, 0); check("wrap_zero", {31'd0, zero}, 1);
    clear_in(); aluopin = 2; regd0in = 5; regd1in = 6; step();
    check("badfunct", aluresult, 0);
    rand_in(); step();
    rand_in(); stall = 1; rst = 1; step();
    for (int i = 0; i < 400; i++) begin
      rand_in();
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 49) == 0);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
